// File: rtl/nec_ir_tx.sv
`default_nettype none
// ============================================================================
// Module   : nec_ir_tx
// Purpose  : NEC-protocol infrared transmitter. Serialises a full NEC data
//            frame (leader, address, ~address, command, ~command, stop) or a
//            repeat code onto an IR LED drive pin, optionally gated by a
//            carrier. All protocol timing is owned here.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   1  system clock
//   reset        in   1  synchronous active-high reset
//   start        in   1  frame request, sampled only while idle
//   repeat_frame in   1  sampled with start; 1 = send repeat code
//                        (the protocol name "repeat" is a reserved word)
//   address      in   8  NEC address byte
//   command      in   8  NEC command byte
//   busy         out  1  high while a frame is in progress
//   done         out  1  one-cycle pulse when a frame completes
//   ir_envelope  out  1  unmodulated envelope, 1 = mark
//   ir_out       out  1  LED drive, active-high
// ============================================================================
module nec_ir_tx #(
    parameter int UNIT_CYCLES  = 28125,
    parameter int CARRIER_HALF = 658,
    parameter bit MODULATE     = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       repeat_frame,
    input  logic [7:0] address,
    input  logic [7:0] command,
    output logic       busy,
    output logic       done,
    output logic       ir_envelope,
    output logic       ir_out
);

    localparam int c_UW = $clog2(UNIT_CYCLES);
    localparam int c_CW = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;
    localparam logic [c_UW-1:0] c_UNIT_LAST = c_UW'(UNIT_CYCLES - 1);
    localparam logic [c_CW-1:0] c_CAR_LAST  = c_CW'(CARRIER_HALF - 1);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_LEAD_MARK  = 3'd1;
    localparam logic [2:0] S_LEAD_SPACE = 3'd2;
    localparam logic [2:0] S_BIT_MARK   = 3'd3;
    localparam logic [2:0] S_BIT_SPACE  = 3'd4;
    localparam logic [2:0] S_RPT_SPACE  = 3'd5;
    localparam logic [2:0] S_STOP_MARK  = 3'd6;

    logic [2:0]      r_state;
    logic [c_UW-1:0] r_unit_cnt;
    logic [4:0]      r_seg_unit;
    logic [4:0]      r_bit_idx;
    logic [31:0]     r_data;
    logic            r_rpt;
    logic [c_CW-1:0] r_car_cnt;
    logic            r_carrier;

    logic [2:0]      w_state_nxt;
    logic [c_UW-1:0] w_unit_nxt;
    logic [4:0]      w_seg_nxt;
    logic [4:0]      w_bit_nxt;
    logic [31:0]     w_data_nxt;
    logic            w_rpt_nxt;
    logic [c_CW-1:0] w_ccnt_nxt;
    logic            w_car_nxt;
    logic            w_env_nxt;
    logic            w_busy_nxt;
    logic            w_done_nxt;
    logic            w_out_nxt;
    logic [4:0]      w_seg_last;
    logic            w_bit_val;

    assign w_bit_val = r_data[r_bit_idx];

    // Last segment-unit index of the current segment (length - 1)
    always_comb begin
        w_seg_last = 5'd0;
        case (r_state)
            S_LEAD_MARK:  w_seg_last = 5'd15;
            S_LEAD_SPACE: w_seg_last = 5'd7;
            S_BIT_SPACE:  w_seg_last = w_bit_val ? 5'd2 : 5'd0;
            S_RPT_SPACE:  w_seg_last = 5'd3;
            default:      w_seg_last = 5'd0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_unit_nxt  = r_unit_cnt;
        w_seg_nxt   = r_seg_unit;
        w_bit_nxt   = r_bit_idx;
        w_data_nxt  = r_data;
        w_rpt_nxt   = r_rpt;
        w_ccnt_nxt  = r_car_cnt;
        w_car_nxt   = r_carrier;
        w_env_nxt   = ir_envelope;
        w_busy_nxt  = busy;
        w_done_nxt  = 1'b0;

        if (r_state == S_IDLE) begin
            if (start) begin
                // Transmission order: address, ~address, command, ~command,
                // each LSB first, so bit index 0 is address[0].
                w_data_nxt  = {~command, command, ~address, address};
                w_rpt_nxt   = repeat_frame;
                w_state_nxt = S_LEAD_MARK;
                w_busy_nxt  = 1'b1;
                w_env_nxt   = 1'b1;
                w_unit_nxt  = '0;
                w_seg_nxt   = '0;
                w_bit_nxt   = '0;
                w_car_nxt   = 1'b1;
                w_ccnt_nxt  = '0;
            end
        end else begin
            // Free-running carrier inside a mark, parked low in a space
            if (ir_envelope) begin
                if (r_car_cnt == c_CAR_LAST) begin
                    w_car_nxt  = ~r_carrier;
                    w_ccnt_nxt = '0;
                end else begin
                    w_ccnt_nxt = r_car_cnt + 1'b1;
                end
            end else begin
                w_car_nxt  = 1'b0;
                w_ccnt_nxt = '0;
            end

            if (r_unit_cnt == c_UNIT_LAST) begin
                w_unit_nxt = '0;
                if (r_seg_unit == w_seg_last) begin
                    w_seg_nxt = '0;
                    case (r_state)
                        S_LEAD_MARK:  w_state_nxt = r_rpt ? S_RPT_SPACE : S_LEAD_SPACE;
                        S_LEAD_SPACE: w_state_nxt = S_BIT_MARK;
                        S_BIT_MARK:   w_state_nxt = S_BIT_SPACE;
                        S_BIT_SPACE: begin
                            if (r_bit_idx == 5'd31) begin
                                w_state_nxt = S_STOP_MARK;
                            end else begin
                                w_state_nxt = S_BIT_MARK;
                                w_bit_nxt   = r_bit_idx + 1'b1;
                            end
                        end
                        S_RPT_SPACE:  w_state_nxt = S_STOP_MARK;
                        default:      w_state_nxt = S_IDLE;
                    endcase

                    // Every mark restarts the carrier in its high phase
                    if ((w_state_nxt == S_BIT_MARK) || (w_state_nxt == S_STOP_MARK)) begin
                        w_env_nxt  = 1'b1;
                        w_car_nxt  = 1'b1;
                        w_ccnt_nxt = '0;
                    end else begin
                        w_env_nxt  = 1'b0;
                        w_car_nxt  = 1'b0;
                        w_ccnt_nxt = '0;
                    end

                    if (w_state_nxt == S_IDLE) begin
                        w_busy_nxt = 1'b0;
                        w_done_nxt = 1'b1;
                    end
                end else begin
                    w_seg_nxt = r_seg_unit + 1'b1;
                end
            end else begin
                w_unit_nxt = r_unit_cnt + 1'b1;
            end
        end
    end

    generate
        if (MODULATE) begin : g_modulated
            assign w_out_nxt = w_env_nxt & w_car_nxt;
        end else begin : g_raw
            assign w_out_nxt = w_env_nxt;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_unit_cnt  <= '0;
            r_seg_unit  <= '0;
            r_bit_idx   <= '0;
            r_data      <= '0;
            r_rpt       <= 1'b0;
            r_car_cnt   <= '0;
            r_carrier   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            ir_envelope <= 1'b0;
            ir_out      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_unit_cnt  <= w_unit_nxt;
            r_seg_unit  <= w_seg_nxt;
            r_bit_idx   <= w_bit_nxt;
            r_data      <= w_data_nxt;
            r_rpt       <= w_rpt_nxt;
            r_car_cnt   <= w_ccnt_nxt;
            r_carrier   <= w_car_nxt;
            busy        <= w_busy_nxt;
            done        <= w_done_nxt;
            ir_envelope <= w_env_nxt;
            ir_out      <= w_out_nxt;
        end
    end

endmodule
`default_nettype wire
